hazard_stall_unit: RTL
======================

// Module: hazard_stall_unit
// PURPOSE
//  Pipeline hazard controller for the 5-stage MIPS datapath, sitting in ID.
//  Detects load-use hazards and taken branches/jumps resolved in ID.
//  Produces PC/IF-ID write enables, the IF/ID flush, and CtrlSel.
//  CtrlSel is the select of the 1-bit control-zeroing muxes in ID/EX
//  (1 = pass decoded controls, 0 = insert bubble).
//  Sequences multi-cycle stalls/flushes and keeps saturating event counters.
// PARAMETERS
//  REG_W          5  register-address width
//  LOAD_STALL_CYC 1  bubble cycles per load-use hazard (1..15)
//  BR_FLUSH_CYC   1  IF/ID flush cycles per taken branch/jump (1..15)
// PORTS
//  Clk            in   1      rising-edge clock
//  Reset          in   1      synchronous, active-high reset
//  ID_Rs          in   REG_W  rs of the instruction in ID
//  ID_Rt          in   REG_W  rt of the instruction in ID
//  ID_UsesRt      in   1      ID instruction reads rt
//  EX_MemRead     in   1      instruction in EX is a load
//  EX_WriteReg    in   REG_W  destination register of the instruction in EX
//  BranchTaken    in   1      branch/jump in ID is taken this cycle
//  PCWrite        out  1      PC register load enable
//  IFIDWrite      out  1      IF/ID register load enable
//  IFFlush        out  1      IF/ID register loads a nop
//  CtrlSel        out  1      ID/EX control mux select (0 = bubble)
//  StallCount     out  32     load-use bubble cycles, saturating
//  FlushCount     out  32     flush cycles, saturating
// BEHAVIOUR
//  hazard = EX_MemRead & (EX_WriteReg != 0) &
//           (EX_WriteReg == ID_Rs | (ID_UsesRt & EX_WriteReg == ID_Rt))
//  FSM states: RUN, STALL, FLUSH. 4-bit counter cnt.
//  Outputs are Mealy in RUN and Moore in STALL/FLUSH. Same-cycle effect, no added latency.
//  RUN, hazard=1:
//   - PCWrite=0, IFIDWrite=0, CtrlSel=0, IFFlush=0.
//   - If LOAD_STALL_CYC>1: next state STALL, cnt <= LOAD_STALL_CYC-1. Else stay in RUN.
//  RUN, hazard=0, BranchTaken=1:
//   - PCWrite=1, IFIDWrite=1, IFFlush=1, CtrlSel=1.
//   - If BR_FLUSH_CYC>1: next state FLUSH, cnt <= BR_FLUSH_CYC-1.
//  RUN, neither: PCWrite=1, IFIDWrite=1, IFFlush=0, CtrlSel=1.
//  Priority: hazard beats BranchTaken. A branch whose operand is a pending load waits.
//  STALL:
//   - Outputs as in the RUN hazard case.
//   - hazard and BranchTaken are ignored.
//   - cnt==1 -> RUN; else cnt <= cnt-1.
//  FLUSH:
//   - PCWrite=1, IFIDWrite=1, IFFlush=1, CtrlSel=1.
//   - hazard and BranchTaken are ignored, since ID holds a nop.
//   - cnt==1 -> RUN; else cnt <= cnt-1.
//  StallCount increments on every cycle with CtrlSel=0 while Reset=0.
//  FlushCount increments on every cycle with IFFlush=1 while Reset=0.
//  Both counters hold at 32'hFFFFFFFF; they never wrap.
//  Reset=1, sampled at a clock edge:
//   - State <= RUN, cnt <= 0, both counters <= 0.
//   - While Reset is high: PCWrite=0, IFIDWrite=0, IFFlush=1, CtrlSel=0, with no counting.
//   - Applies from any state, including mid-STALL or mid-FLUSH.
//   - First cycle after release: RUN rules.
// TESTING
//  1. lw $t0 in EX (WriteReg=8); ID add with rs=8; LOAD_STALL_CYC=1
//     -> one cycle PCWrite=IFIDWrite=CtrlSel=0; next cycle all 1; StallCount=1.
//  2. Load in EX with WriteReg=0 and ID_Rs=0
//     -> no stall; CtrlSel stays 1.
//  3. Load WriteReg=9 matching ID_Rt=9 with ID_UsesRt=0
//     -> no stall. Same case with ID_UsesRt=1 -> stall.
//  4. LOAD_STALL_CYC=3, hazard pulsed 1 cycle -> exactly 3 bubble cycles.
//     BranchTaken=1 during cycles 2-3 is ignored; StallCount=3.
//  5. BR_FLUSH_CYC=2, BranchTaken=1 for 1 cycle -> IFFlush=1 for 2 cycles, PCWrite=1.
//     Simultaneous hazard+BranchTaken -> stall only, IFFlush=0.
//  6. Reset asserted in the 2nd STALL cycle -> counters 0, safe outputs.
//     After release: RUN; a new hazard stalls again normally.
//     Preload StallCount near max (force) -> saturates at FFFFFFFF.

Source files
------------

// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit
//  Hazard controller for a 5-stage MIPS pipeline, located in ID.
//  It detects two conditions:
//   - a load-use hazard: the load in EX writes a register that the ID
//     instruction reads;
//   - a taken branch or jump that is resolved in ID.
//  For each one it drives the PC and IF/ID enables, the IF/ID flush and the
//  ID/EX control-zeroing select. It can hold a stall or a flush for several
//  cycles, and it keeps saturating counts of bubble cycles and flush cycles.
// Ports
//  Clk, Reset           rising-edge clock, synchronous active-high reset
//  ID_Rs, ID_Rt         source registers of the instruction in ID
//  ID_UsesRt            the ID instruction really reads rt
//  EX_MemRead           the instruction in EX is a load
//  EX_WriteReg          destination register of the instruction in EX
//  BranchTaken          the branch/jump in ID is taken this cycle
//  PCWrite, IFIDWrite   load enables for PC and IF/ID
//  IFFlush              IF/ID loads a nop
//  CtrlSel              ID/EX control select (1 = decoded controls, 0 = bubble)
//  StallCount           saturating count of bubble cycles (CtrlSel = 0)
//  FlushCount           saturating count of flush cycles (IFFlush = 1)
module hazard_stall_unit #(
  parameter int REG_W          = 5,
  parameter int LOAD_STALL_CYC = 1,
  parameter int BR_FLUSH_CYC   = 1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [REG_W-1:0] ID_Rs,
  input  logic [REG_W-1:0] ID_Rt,
  input  logic             ID_UsesRt,
  input  logic             EX_MemRead,
  input  logic [REG_W-1:0] EX_WriteReg,
  input  logic             BranchTaken,
  output logic             PCWrite,
  output logic             IFIDWrite,
  output logic             IFFlush,
  output logic             CtrlSel,
  output logic [31:0]      StallCount,
  output logic [31:0]      FlushCount
);

  typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;

  // The first cycle of a stall or flush is spent in RUN. The counter
  // therefore holds only the cycles that remain after that first one.
  localparam logic [3:0] STALL_RELOAD = 4'(LOAD_STALL_CYC - 1);
  localparam logic [3:0] FLUSH_RELOAD = 4'(BR_FLUSH_CYC - 1);

  state_t     state;
  logic [3:0] cnt;
  logic       hazard;

  // Register $zero is never a real dependency, so a write to it is ignored.
  assign hazard = EX_MemRead && (EX_WriteReg != '0) &&
                  ((EX_WriteReg == ID_Rs) || (ID_UsesRt && (EX_WriteReg == ID_Rt)));

  // In RUN the outputs follow the inputs in the same cycle (Mealy).
  // In STALL and FLUSH they depend only on the state (Moore).
  // While Reset is high the outputs take a safe value: nothing advances,
  // IF/ID takes a nop and ID/EX takes a bubble.
  always_comb begin
    PCWrite   = 1'b1;
    IFIDWrite = 1'b1;
    IFFlush   = 1'b0;
    CtrlSel   = 1'b1;
    if (Reset) begin
      PCWrite   = 1'b0;
      IFIDWrite = 1'b0;
      IFFlush   = 1'b1;
      CtrlSel   = 1'b0;
    end else begin
      unique case (state)
        RUN: begin
          // A hazard has priority: a branch that depends on a pending load
          // waits in ID until the load data is available.
          if (hazard) begin
            PCWrite   = 1'b0;
            IFIDWrite = 1'b0;
            CtrlSel   = 1'b0;
          end else if (BranchTaken) begin
            IFFlush = 1'b1;
          end
        end
        STALL: begin
          PCWrite   = 1'b0;
          IFIDWrite = 1'b0;
          CtrlSel   = 1'b0;
        end
        FLUSH: IFFlush = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= RUN;
      cnt        <= 4'd0;
      StallCount <= 32'd0;
      FlushCount <= 32'd0;
    end else begin
      unique case (state)
        RUN: begin
          if (hazard) begin
            if (LOAD_STALL_CYC > 1) begin
              state <= STALL;
              cnt   <= STALL_RELOAD;
            end
          end else if (BranchTaken && (BR_FLUSH_CYC > 1)) begin
            state <= FLUSH;
            cnt   <= FLUSH_RELOAD;
          end
        end
        // While in STALL or FLUSH, hazard and BranchTaken are ignored.
        // The instruction in ID is either held or is already a nop.
        STALL, FLUSH: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= RUN;
        end
        default: state <= RUN;
      endcase
      if (!CtrlSel && (StallCount != 32'hFFFF_FFFF)) StallCount <= StallCount + 32'd1;
      if (IFFlush && (FlushCount != 32'hFFFF_FFFF)) FlushCount <= FlushCount + 32'd1;
    end
  end

endmodule
